// File: rtl/uart_rx_tx_fifo_pkg.sv
// Shared definitions for the UART echo-path byte FIFO.
//  - Default widths and depth used by the FIFO, its interface and the
//    uart_rx/uart_tx blocks that sit on either side of it.
//  - Transmit handshake FSM state encoding.
//  - Saturating 8-bit increment used by the optional dropped-byte counter
//    (UART_FIFO_OVF_CNT_EN).
package uart_rx_tx_fifo_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int DEPTH_LOG2_DEF  = 4;
    localparam int ACK_TIMEOUT_DEF = 64;

    // Transmit handshake states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT_LO = 2'd2,
        ST_WAIT_HI = 2'd3
    } tx_state_t;

    // Increment that sticks at 255 instead of wrapping to 0
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_tx_fifo_if.sv
// Bundle of all non-clock/reset signals of the UART echo FIFO.
//  in_valid/in_data : push strobe and byte from uart_rx
//  tx_rdy           : uart_tx idle flag
//  tx_start/tx_data : start pulse and byte to uart_tx
//  ovf_clr          : clears sticky overflow (and ovf_cnt)
//  count/empty/full/overflow : status
//  ovf_cnt          : dropped-byte count, present only with UART_FIFO_OVF_CNT_EN
// Modports: master = environment driving the FIFO, slave = the FIFO itself.
interface uart_rx_tx_fifo_if
    import uart_rx_tx_fifo_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
);

    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  tx_rdy;
    logic                  tx_start;
    logic [DATA_W-1:0]     tx_data;
    logic                  ovf_clr;
    logic [DEPTH_LOG2:0]   count;
    logic                  empty;
    logic                  full;
    logic                  overflow;
`ifdef UART_FIFO_OVF_CNT_EN
    logic [7:0]            ovf_cnt;

    modport master (
        output in_valid, in_data, tx_rdy, ovf_clr,
        input  tx_start, tx_data, count, empty, full, overflow, ovf_cnt
    );

    modport slave (
        input  in_valid, in_data, tx_rdy, ovf_clr,
        output tx_start, tx_data, count, empty, full, overflow, ovf_cnt
    );
`else
    modport master (
        output in_valid, in_data, tx_rdy, ovf_clr,
        input  tx_start, tx_data, count, empty, full, overflow
    );

    modport slave (
        input  in_valid, in_data, tx_rdy, ovf_clr,
        output tx_start, tx_data, count, empty, full, overflow
    );
`endif

endinterface

// File: rtl/uart_rx_tx_fifo_mem.sv
// Storage array for the UART echo FIFO.
//  clk, rst : clock, asynchronous active-high reset (read register only)
//  wr_en, wr_addr, wr_data : single write port
//  rd_en, rd_addr          : read request
//  rd_data                 : registered read data, updated only on rd_en,
//                            so it holds the last popped byte
// The array itself is not reset.
module uart_rx_tx_fifo_mem #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem_r [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rd_data_r;

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; a same-edge write to the read address returns the old byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/uart_rx_tx_fifo.sv
// Byte FIFO between uart_rx and uart_tx in the echo path.
//  clk : system clock (rising edge)
//  rst : asynchronous active-high reset; discards buffered bytes and any
//        pending start
//  bus : uart_rx_tx_fifo_if.slave (push side, uart_tx handshake, status)
// A pop happens when the handshake FSM is idle, tx_rdy is high and the FIFO
// holds data; tx_start follows one cycle later with the popped byte on
// tx_data. The FSM then waits for uart_tx to drop tx_rdy (or gives up after
// ACK_TIMEOUT cycles) and for tx_rdy to rise again before the next pop.
// Optional feature macro: UART_FIFO_OVF_CNT_EN adds the saturating ovf_cnt.
module uart_rx_tx_fifo
    import uart_rx_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_tx_fifo_if.slave  bus
);

    localparam int                  CW           = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]       DEPTH_CNT    = CW'(2**DEPTH_LOG2);
    localparam logic [7:0]          TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;
    logic                  empty_r;
    logic                  full_r;
    logic                  overflow_r;
    logic                  tx_start_r;
    logic [7:0]            timer_r;
    tx_state_t             state_r;
    tx_state_t             state_next_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  drop_s;
    logic [DATA_W-1:0]     rd_data_s;

    // Handshake qualifiers; a pop frees a slot in the same cycle so a push into a full FIFO is kept
    always_comb begin
        pop_s  = (state_r == ST_IDLE) && bus.tx_rdy && !empty_r;
        push_s = bus.in_valid && (!full_r || pop_s);
        drop_s = bus.in_valid && full_r && !pop_s;
    end

    // Next occupancy from this cycle's push/pop
    always_comb begin
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers, occupancy and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
            end
            count_r <= count_next_s;
            empty_r <= (count_next_s == CW'(0));
            full_r  <= (count_next_s == DEPTH_CNT);
        end
    end

    // Sticky overflow; a drop in the same cycle as ovf_clr keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_r <= 1'b0;
        end
    end

`ifdef UART_FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt_r;

    // Dropped-byte counter; clear takes priority over a same-cycle drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_r <= 8'd0;
        end else if (bus.ovf_clr) begin
            ovf_cnt_r <= 8'd0;
        end else if (drop_s) begin
            ovf_cnt_r <= sat_inc8(ovf_cnt_r);
        end
    end

    assign bus.ovf_cnt = ovf_cnt_r;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; WAIT_LO gives up when tx_rdy never falls within ACK_TIMEOUT cycles
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_next_s = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!bus.tx_rdy) begin
                    state_next_s = ST_WAIT_HI;
                end else if (timer_r == TIMEOUT_LAST) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_LO;
                end
            end
            ST_WAIT_HI: begin
                if (bus.tx_rdy) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_HI;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Cycles spent in WAIT_LO; cleared in every other state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r <= 8'd0;
        end else if (state_r == ST_WAIT_LO) begin
            timer_r <= timer_r + 8'd1;
        end else begin
            timer_r <= 8'd0;
        end
    end

    // Start pulse is high exactly in the START cycle that follows a pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_start_r <= 1'b0;
        end else begin
            tx_start_r <= pop_s;
        end
    end

    uart_rx_tx_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (bus.in_data),
        .rd_en   (pop_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    assign bus.tx_start = tx_start_r;
    assign bus.tx_data  = rd_data_s;
    assign bus.count    = count_r;
    assign bus.empty    = empty_r;
    assign bus.full     = full_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_uart_rx_tx_fifo.sv
// Self-checking bench for uart_rx_tx_fifo. Accepted bytes are queued in an
// expected-order scoreboard; a monitor pops and compares on every tx_start.
// A small uart_tx emulator answers start pulses by dropping tx_rdy.
module tb_uart_rx_tx_fifo;
    import uart_rx_tx_fifo_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    uart_rx_tx_fifo_if bus ();

    uart_rx_tx_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    int         n_starts   = 0;
    int         last_start = -100;
    int         prev_start = -100;
    logic [7:0] mon_exp;

    bit emu_on    = 1'b0;
    int emu_lo    = 2;
    int emu_phase = 0;
    int emu_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every start pulse must carry the next expected byte
    always @(negedge clk) begin
        if (!rst && bus.tx_start) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_start: got data %0h with empty scoreboard (cycle %0d)", bus.tx_data, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("tx_data_order", bus.tx_data, mon_exp);
            end
            if (n_starts > 0) chk("start_spacing_ge4", (cyc - last_start) >= 4, 1);
            prev_start = last_start;
            last_start = cyc;
            n_starts++;
        end
    end

    // uart_tx emulator: tx_rdy falls 2 cycles after start, low for emu_lo cycles
    always @(negedge clk) begin
        if (emu_on && !rst) begin
            case (emu_phase)
                0: if (bus.tx_start) begin emu_phase = 1; emu_cnt = 2; end
                1: begin
                    emu_cnt--;
                    if (emu_cnt == 0) begin bus.tx_rdy = 1'b0; emu_phase = 2; emu_cnt = emu_lo; end
                end
                default: begin
                    emu_cnt--;
                    if (emu_cnt <= 0) begin bus.tx_rdy = 1'b1; emu_phase = 0; end
                end
            endcase
        end
    end

    // One-cycle push; the model accepts if there is room or a pop is known to coincide
    task automatic push(input logic [7:0] d, input bit pop_known);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        if (exp_q.size() < DEPTH || pop_known) exp_q.push_back(d);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d bytes still expected after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic check_idle_status(input string tag);
        chk({tag, "_count"}, bus.count, 0);
        chk({tag, "_empty"}, bus.empty, 1);
        chk({tag, "_full"},  bus.full,  0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, s0, guard;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.tx_rdy   = 1'b0;
        bus.ovf_clr  = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_status("reset");
        chk("reset_tx_start", bus.tx_start, 0);
        chk("reset_tx_data",  bus.tx_data,  0);
        chk("reset_overflow", bus.overflow, 0);
`ifdef UART_FIFO_OVF_CNT_EN
        chk("reset_ovf_cnt", bus.ovf_cnt, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // 1: single byte latency
        bus.tx_rdy = 1'b1;
        emu_lo = 2;
        emu_on = 1'b1;
        @(negedge clk);
        n0 = cyc;
        s0 = n_starts;
        push(8'h41, 1'b0);
        chk("t1_count_after_push", bus.count, 1);
        @(negedge clk);
        chk("t1_count_after_pop", bus.count, 0);
        repeat (10) @(negedge clk);
        chk("t1_single_start", n_starts - s0, 1);
        chk("t1_latency", last_start - n0, 2);
        chk("t1_empty", bus.empty, 1);

        // 2: fill while uart_tx is busy, then drain in order
        emu_on = 1'b0;
        bus.tx_rdy = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
        chk("t2_count_full", bus.count, 16);
        chk("t2_full", bus.full, 1);
        chk("t2_not_empty", bus.empty, 0);
        s0 = n_starts;
        bus.tx_rdy = 1'b1;
        emu_on = 1'b1;
        wait_drain(600);
        chk("t2_start_count", n_starts - s0, 16);
        check_idle_status("t2_end");

        // 3: overflow and clear
        emu_on = 1'b0;
        bus.tx_rdy = 1'b0;
        for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)), 1'b0);
        push(8'hAA, 1'b0);
        chk("t3_overflow", bus.overflow, 1);
        chk("t3_count_kept", bus.count, 16);
`ifdef UART_FIFO_OVF_CNT_EN
        chk("t3_ovf_cnt", bus.ovf_cnt, 1);
`endif
        bus.ovf_clr = 1'b1;
        push(8'hAB, 1'b0);
        bus.ovf_clr = 1'b0;
        chk("t3_overflow_clr_loses", bus.overflow, 1);
`ifdef UART_FIFO_OVF_CNT_EN
        chk("t3_ovf_cnt_clr_wins", bus.ovf_cnt, 0);
`endif
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        chk("t3_overflow_cleared", bus.overflow, 0);
`ifdef UART_FIFO_OVF_CNT_EN
        chk("t3_ovf_cnt_cleared", bus.ovf_cnt, 0);
`endif

        // 4: push into full FIFO in the same cycle as a pop
        bus.tx_rdy = 1'b1;
        emu_on = 1'b1;
        push(8'h55, 1'b1);
        chk("t4_count_stays_full", bus.count, 16);
        chk("t4_no_overflow", bus.overflow, 0);
        wait_drain(800);
        check_idle_status("t4_end");
        chk("t4_overflow_end", bus.overflow, 0);

        // 5: tx_rdy stuck high -> ack timeout, then pointer wrap with random traffic
        emu_on = 1'b0;
        bus.tx_rdy = 1'b1;
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        wait_drain(300);
        chk("t5_timeout_gap", last_start - prev_start, 66);
        repeat (70) @(negedge clk);
        emu_on = 1'b1;
        for (int i = 0; i < 80; i++) begin
            guard = 0;
            while (exp_q.size() >= 12 && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            emu_lo = $urandom_range(1, 4);
            push(8'($urandom_range(0, 255)), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain(3000);
        check_idle_status("t5_end");
        chk("t5_overflow", bus.overflow, 0);

        // 6: reset while waiting for tx_rdy to rise with bytes queued
        emu_on = 1'b0;
        bus.tx_rdy = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i), 1'b0);
        bus.tx_rdy = 1'b1;
        @(negedge clk);
        bus.tx_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_queued_before_reset", bus.count, 4);
        rst = 1'b1;
        #1;
        exp_q.delete();
        s0 = n_starts;
        check_idle_status("t6_reset");
        chk("t6_reset_tx_start", bus.tx_start, 0);
        chk("t6_reset_tx_data",  bus.tx_data,  0);
        chk("t6_reset_overflow", bus.overflow, 0);
`ifdef UART_FIFO_OVF_CNT_EN
        chk("t6_reset_ovf_cnt", bus.ovf_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.tx_rdy = 1'b1;
        emu_phase = 0;
        emu_on = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_no_start_after_reset", n_starts - s0, 0);
        push(8'h7E, 1'b0);
        wait_drain(60);
        chk("t6_one_start_after_push", n_starts - s0, 1);
        check_idle_status("t6_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
